// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - channel-scan sequencer for an 8:1 mux with valid/ready capture
module mux_scan_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       chan_en,
  input  logic [WIDTH-1:0] mux_y,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_OUT, S_DONE} state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t           state, state_nx;
  logic [7:0]       mask, mask_nx, remain;
  logic [3:0]       cnt, cnt_nx;
  logic [2:0]       sel_nx, chan_nx;
  logic [WIDTH-1:0] data_nx;
  logic             valid_nx;

  // Index of the lowest set bit; lower bits are already consumed, so this is
  // also the next higher channel once the current bit is cleared.
  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // State and datapath registers, cleared asynchronously so no beat survives reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mask      <= 8'd0;
      cnt       <= 4'd0;
      sel       <= 3'd0;
      out_data  <= '0;
      out_chan  <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      mask      <= mask_nx;
      cnt       <= cnt_nx;
      sel       <= sel_nx;
      out_data  <= data_nx;
      out_chan  <= chan_nx;
      out_valid <= valid_nx;
    end
  end

  // Next-state and next-register decode; everything holds unless a state acts on it
  always_comb begin
    state_nx = state;
    mask_nx  = mask;
    cnt_nx   = cnt;
    sel_nx   = sel;
    data_nx  = out_data;
    chan_nx  = out_chan;
    valid_nx = out_valid;
    remain   = mask & ~(8'd1 << sel);
    case (state)
      S_IDLE: begin
        if (start) begin
          if (chan_en != 8'd0) begin
            mask_nx  = chan_en;
            sel_nx   = lowest(chan_en);
            cnt_nx   = SETTLE_CNT;
            state_nx = S_SETTLE;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_SETTLE: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          data_nx  = mux_y;
          chan_nx  = sel;
          valid_nx = 1'b1;
          state_nx = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          valid_nx = 1'b0;
          mask_nx  = remain;
          if (remain != 8'd0) begin
            sel_nx   = lowest(remain);
            cnt_nx   = SETTLE_CNT;
            state_nx = S_SETTLE;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        sel_nx   = 3'd0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_SETTLE) || (state == S_OUT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed self-checking bench for mux_scan_ctrl
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start1, rdy1, valid1, busy1, done1;
  logic [7:0] en1;
  logic [3:0] y1, data1;
  logic [2:0] sel1, chan1;

  logic       start3, rdy3, valid3, busy3, done3;
  logic [7:0] en3;
  logic [3:0] y3, data3;
  logic [2:0] sel3, chan3;

  int checks   = 0;
  int failures = 0;
  int acc1     = 0;
  int base;

  always #5 clk = ~clk;

  mux_scan_ctrl #(.WIDTH(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .chan_en(en1), .mux_y(y1),
    .sel(sel1), .out_data(data1), .out_chan(chan1), .out_valid(valid1),
    .out_ready(rdy1), .busy(busy1), .done(done1)
  );

  mux_scan_ctrl #(.WIDTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .chan_en(en3), .mux_y(y3),
    .sel(sel3), .out_data(data3), .out_chan(chan3), .out_valid(valid3),
    .out_ready(rdy3), .busy(busy3), .done(done3)
  );

  // dut1 sees an ideal mux (channel i -> i); dut3 sees Y one cycle after sel moves
  assign y1 = 4'(sel1);
  always @(posedge clk) y3 <= 4'(sel3) + 4'h5;

  always @(posedge clk) if (valid1 && rdy1) acc1 <= acc1 + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid1();
    for (int n = 0; n < 20 && !valid1; n++) tick();
    check("wait_valid1", 32'(valid1), 32'd1);
  endtask

  initial begin
    int exp_ch[3];
    exp_ch = '{2, 5, 7};
    rst = 1'b1;
    start1 = 0; en1 = 0; rdy1 = 0;
    start3 = 0; en3 = 0; rdy3 = 0;
    repeat (2) tick();
    check("rst_sel", 32'(sel1), 0);
    check("rst_valid", 32'(valid1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_data", 32'(data1), 0);
    check("rst_chan", 32'(chan1), 0);
    rst = 1'b0;
    tick();

    // Full mask, SETTLE=1: one beat every two cycles, then one done pulse
    start1 = 1; en1 = 8'hFF; rdy1 = 1;
    tick();
    start1 = 0; en1 = 8'h00;
    check("t2_busy", 32'(busy1), 1);
    check("t2_sel0", 32'(sel1), 0);
    check("t2_valid0", 32'(valid1), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_valid", 32'(valid1), 1);
      check("t2_chan", 32'(chan1), 32'(i));
      check("t2_data", 32'(data1), 32'(i));
      tick();
      check("t2_drop", 32'(valid1), 0);
      if (i < 7) check("t2_nsel", 32'(sel1), 32'(i + 1));
      else       check("t2_done", 32'(done1), 1);
    end
    tick();
    check("t2_done_off", 32'(done1), 0);
    check("t2_idle", 32'(busy1), 0);
    check("t2_sel_clr", 32'(sel1), 0);
    check("t2_accepts", 32'(acc1), 8);

    // Sparse mask with three stalled cycles per beat
    base = acc1;
    rdy1 = 0; start1 = 1; en1 = 8'b1010_0100;
    tick();
    start1 = 0; en1 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      wait_valid1();
      check("t3_chan", 32'(chan1), 32'(exp_ch[k]));
      check("t3_data", 32'(data1), 32'(exp_ch[k]));
      repeat (3) begin
        tick();
        check("t3_hold_v", 32'(valid1), 1);
        check("t3_hold_d", 32'(data1), 32'(exp_ch[k]));
        check("t3_hold_s", 32'(sel1), 32'(exp_ch[k]));
      end
      rdy1 = 1;
      tick();
      rdy1 = 0;
    end
    check("t3_done", 32'(done1), 1);
    tick();
    check("t3_accepts", 32'(acc1 - base), 3);

    // Empty mask: straight to done, no beat
    start1 = 1; en1 = 8'h00;
    tick();
    start1 = 0;
    check("t4_done", 32'(done1), 1);
    check("t4_busy", 32'(busy1), 0);
    check("t4_valid", 32'(valid1), 0);
    tick();
    check("t4_done_off", 32'(done1), 0);
    check("t4_valid2", 32'(valid1), 0);
    check("t4_busy2", 32'(busy1), 0);

    // start/chan_en activity mid-scan is ignored; start held into IDLE relaunches
    rdy1 = 1; start1 = 1; en1 = 8'h03;
    tick();
    en1 = 8'h80;
    tick();
    check("t6_v0", 32'(valid1), 1);
    check("t6_c0", 32'(chan1), 0);
    tick();
    tick();
    check("t6_v1", 32'(valid1), 1);
    check("t6_c1", 32'(chan1), 1);
    tick();
    check("t6_done", 32'(done1), 1);
    tick();
    check("t6_idle", 32'(busy1), 0);
    check("t6_done_off", 32'(done1), 0);
    tick();
    check("t6_relaunch", 32'(busy1), 1);
    check("t6_sel7", 32'(sel1), 7);
    start1 = 0;
    tick();
    check("t6_c7", 32'(chan1), 7);
    check("t6_d7", 32'(data1), 7);
    tick();
    check("t6_done2", 32'(done1), 1);
    tick();

    // SETTLE=3 with a mux whose Y lags sel by one cycle
    start3 = 1; en3 = 8'h48; rdy3 = 0;
    tick();
    start3 = 0;
    check("t5_sel3", 32'(sel3), 3);
    check("t5_v_e0", 32'(valid3), 0);
    tick();
    check("t5_v_e1", 32'(valid3), 0);
    tick();
    check("t5_v_e2", 32'(valid3), 0);
    tick();
    check("t5_v_e3", 32'(valid3), 1);
    check("t5_d3", 32'(data3), 32'h8);
    check("t5_c3", 32'(chan3), 3);
    rdy3 = 1;
    tick();
    rdy3 = 0;
    check("t5_sel6", 32'(sel3), 6);
    check("t5_v_e4", 32'(valid3), 0);
    tick();
    tick();
    check("t5_v_e6", 32'(valid3), 0);
    tick();
    check("t5_v_e7", 32'(valid3), 1);
    check("t5_d6", 32'(data3), 32'hB);
    check("t5_c6", 32'(chan3), 6);
    rdy3 = 1;
    tick();
    rdy3 = 0;
    check("t5_done", 32'(done3), 1);
    tick();

    // Asynchronous reset while a beat is held
    rdy1 = 0; start1 = 1; en1 = 8'h10;
    tick();
    start1 = 0;
    tick();
    check("t1_pre_v", 32'(valid1), 1);
    check("t1_pre_c", 32'(chan1), 4);
    #2 rst = 1'b1;
    #1;
    check("t1_valid", 32'(valid1), 0);
    check("t1_data", 32'(data1), 0);
    check("t1_chan", 32'(chan1), 0);
    check("t1_sel", 32'(sel1), 0);
    check("t1_busy", 32'(busy1), 0);
    check("t1_done", 32'(done1), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t1_post_busy", 32'(busy1), 0);
    check("t1_post_valid", 32'(valid1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
